// File: rtl/spad_pkg.sv
// Shared types and helpers for the SPAD pixel-group front end.
package spad_pkg;

  localparam int NUM_PIX = 16;
  localparam int HIT_W   = 5;

  typedef enum logic [1:0] {
    DEAD  = 2'd0,
    ARMED = 2'd1,
    GATE  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  function automatic logic [HIT_W-1:0] popcount(input logic [NUM_PIX-1:0] v);
    logic [HIT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_PIX; i++) c = c + HIT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/spad_sync_edge.sv
// Multi-stage synchronizer for the async photon line plus a rising-edge detector.
module spad_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_auto,
  input  logic i_async,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  always_ff @(posedge clk or negedge rst_auto) begin
    if (!rst_auto) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_hist <= r_sync[STAGES-1];
    end
  end

  // History clears on re-arm, so a photon held high reads as a fresh edge.
  assign o_rise = r_sync[STAGES-1] & ~r_hist;

endmodule

// File: rtl/spad_frontend.sv
// 4x4 SPAD group front end: dead-time hold-off, single latched trigger per
// arm cycle, fixed-width time gate and a popcount of the firing pixels.
module spad_frontend
  import spad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int GATE_CYCLES = 2,
  parameter int DEAD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_auto,
  input  logic               photon,
  input  logic [NUM_PIX-1:0] spaden,
  output logic               trig,
  output logic               time_gate,
  output logic [HIT_W-1:0]   hit_cnt,
  output logic               armed
);

  localparam int CMAX  = (DEAD_CYCLES > GATE_CYCLES) ? DEAD_CYCLES : GATE_CYCLES;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYCLES);
  localparam logic [CNT_W-1:0] GATE_END = CNT_W'(GATE_CYCLES);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_trig, w_trig_nxt;
  logic             r_gate, w_gate_nxt;
  logic [HIT_W-1:0] r_hit, w_hit_nxt;
  logic             r_armed, w_armed_nxt;
  logic             w_rise;

  spad_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_auto (rst_auto),
    .i_async  (photon),
    .o_rise   (w_rise)
  );

  always_ff @(posedge clk or negedge rst_auto) begin
    if (!rst_auto) begin
      r_state <= DEAD;
      r_cnt   <= '0;
      r_trig  <= 1'b0;
      r_gate  <= 1'b0;
      r_hit   <= '0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_trig  <= w_trig_nxt;
      r_gate  <= w_gate_nxt;
      r_hit   <= w_hit_nxt;
      r_armed <= w_armed_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_trig_nxt  = r_trig;
    w_gate_nxt  = r_gate;
    w_hit_nxt   = r_hit;
    unique case (r_state)
      // Edges seen here, including the completing cycle, are discarded.
      DEAD: begin
        if (r_cnt == DEAD_END) begin
          w_state_nxt = ARMED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ARMED: begin
        if (w_rise && (|spaden)) begin
          w_state_nxt = GATE;
          w_trig_nxt  = 1'b1;
          w_gate_nxt  = 1'b1;
          w_hit_nxt   = popcount(spaden);
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      GATE: begin
        if (r_cnt == GATE_END) begin
          w_state_nxt = HOLD;
          w_gate_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        w_state_nxt = HOLD;
      end
      default: begin
        w_state_nxt = DEAD;
        w_cnt_nxt   = '0;
      end
    endcase
    w_armed_nxt = (w_state_nxt == ARMED);
  end

  assign trig      = r_trig;
  assign time_gate = r_gate;
  assign hit_cnt   = r_hit;
  assign armed     = r_armed;

endmodule

// File: tb/tb_spad_frontend.sv
// Directed bench for spad_frontend with default parameters.
module tb_spad_frontend;

  logic        clk = 1'b0;
  logic        rst_auto;
  logic        photon;
  logic [15:0] spaden;
  logic        trig, time_gate, armed;
  logic [4:0]  hit_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int trig_rises = 0;
  logic trig_d = 1'b0;

  typedef struct {
    logic [15:0] en;
    logic [4:0]  hit;
  } vec_t;
  vec_t vt[6];

  spad_frontend dut (
    .clk       (clk),
    .rst_auto  (rst_auto),
    .photon    (photon),
    .spaden    (spaden),
    .trig      (trig),
    .time_gate (time_gate),
    .hit_cnt   (hit_cnt),
    .armed     (armed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (trig && !trig_d) trig_rises++;
    trig_d = trig;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input logic t, input logic g,
                         input logic [4:0] h, input logic a);
    chk({name, ".trig"}, 32'(trig), 32'(t));
    chk({name, ".gate"}, 32'(time_gate), 32'(g));
    chk({name, ".hit"}, 32'(hit_cnt), 32'(h));
    chk({name, ".armed"}, 32'(armed), 32'(a));
  endtask

  // Pulse rst_auto low, check the async clear, then watch the dead window.
  task automatic rearm(input string name);
    rst_auto = 1'b0;
    #2;
    chk_all({name, ".rst"}, 1'b0, 1'b0, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_auto = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk({name, ".dead_armed"}, 32'(armed), 32'd0);
      chk({name, ".dead_trig"}, 32'(trig), 32'd0);
    end
    tick();
    chk({name, ".armed"}, 32'(armed), 32'd1);
  endtask

  // From ARMED with photon low and settled: raise photon and follow the gate.
  task automatic fire(input string name, input logic [15:0] en, input logic [4:0] hit);
    spaden = en;
    photon = 1'b1;
    tick();
    tick();
    chk({name, ".e2_trig"}, 32'(trig), 32'd0);
    tick();
    chk_all({name, ".e3"}, 1'b1, 1'b1, hit, 1'b0);
    spaden = ~en;
    tick();
    chk({name, ".e4_gate"}, 32'(time_gate), 32'd1);
    tick();
    chk_all({name, ".e5"}, 1'b1, 1'b0, hit, 1'b0);
  endtask

  // Re-arm with a photon edge landing in the dead window (at=0: held through reset).
  task automatic dead_drop(input string name, input int at);
    photon = (at == 0);
    spaden = 16'hFFFF;
    rst_auto = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst_auto = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == at) photon = 1'b1;
    end
    chk({name, ".armed"}, 32'(armed), 32'd1);
    repeat (5) tick();
    chk({name, ".trig"}, 32'(trig), 32'd0);
    chk({name, ".still_armed"}, 32'(armed), 32'd1);
    photon = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int r0;
    vt[0] = '{16'h00FF, 5'd8};
    vt[1] = '{16'h0FFF, 5'd12};
    vt[2] = '{16'hFFFF, 5'd16};
    vt[3] = '{16'h8001, 5'd2};
    vt[4] = '{16'h0001, 5'd1};
    vt[5] = '{16'hA5A5, 5'd8};

    rst_auto = 1'b0;
    photon   = 1'b0;
    spaden   = 16'h0000;
    #3;
    chk_all("por", 1'b0, 1'b0, 5'd0, 1'b0);
    rearm("init");

    fire("f000F", 16'h000F, 5'd4);

    // Second edge while holding: nothing moves.
    photon = 1'b0;
    repeat (3) tick();
    photon = 1'b1;
    spaden = 16'hFFFF;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_all("hold", 1'b1, 1'b0, 5'd4, 1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      photon = 1'b0;
      rearm("tbl");
      r0 = trig_rises;
      fire("tbl", vt[i].en, vt[i].hit);
      repeat (4) tick();
      chk("tbl.one_trig", 32'(trig_rises - r0), 32'd1);
    end

    // No enabled pixel: edge ignored, remain armed.
    photon = 1'b0;
    rearm("nopix");
    spaden = 16'h0000;
    photon = 1'b1;
    repeat (6) tick();
    chk_all("nopix", 1'b0, 1'b0, 5'd0, 1'b1);
    photon = 1'b0;
    repeat (3) tick();
    fire("nopix_then", 16'h0010, 5'd1);

    dead_drop("dd_held", 0);
    fire("dd_held_fresh", 16'h0003, 5'd2);
    dead_drop("dd_early", 1);
    fire("dd_early_fresh", 16'h0007, 5'd3);
    dead_drop("dd_edge", 2);
    fire("dd_edge_fresh", 16'h001F, 5'd5);

    // Reset one cycle into the gate truncates everything at once.
    photon = 1'b0;
    rearm("mg_pre");
    spaden = 16'h00F0;
    photon = 1'b1;
    repeat (3) tick();
    chk("mg.trig", 32'(trig), 32'd1);
    tick();
    chk("mg.gate", 32'(time_gate), 32'd1);
    photon = 1'b0;
    rearm("midgate");
    fire("mg_after", 16'h0F00, 5'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
